// File: rtl/serial_rx_port.sv
// serial_rx_port: 8N1 UART receiver (LSB first) feeding a first-word-fall-through
// byte FIFO, with sticky framing and overrun flags for the SoC register decoder.
module serial_rx_port #(
  parameter int CLK_DIV = 104,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serial_rx,
  input  logic                   rd_pop,
  input  logic                   clr_err,
  output logic [7:0]             data_out,
  output logic                   data_avail,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [15:0]   HALF_LOAD = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0]   BIT_LOAD  = 16'(CLK_DIV - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1'b1);
  localparam logic [LW-1:0] LVL_ZERO  = LW'(1'b0);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  logic            sync1_r;
  logic            rxs_r;
  rx_state_t       state_r;
  rx_state_t       state_nxt_s;
  logic [15:0]     cnt_r;
  logic [15:0]     cnt_nxt_s;
  logic [2:0]      bit_idx_r;
  logic [2:0]      bit_idx_nxt_s;
  logic [7:0]      shift_r;
  logic [7:0]      shift_nxt_s;
  logic            push_s;
  logic            ferr_set_s;

  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [LW-1:0]   level_nxt_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            pop_s;
  logic            wr_en_s;
  logic            ovr_set_s;
  logic            frame_err_r;
  logic            overrun_r;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= serial_rx;
      rxs_r   <= sync1_r;
    end
  end

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // Frame decoding: start-bit qualification at mid-bit, 8 data samples, stop check.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    push_s        = 1'b0;
    ferr_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          cnt_nxt_s   = HALF_LOAD;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == 16'd0) begin
          if (rxs_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s     = BIT_LOAD;
            bit_idx_nxt_s = 3'd0;
            state_nxt_s   = ST_DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_r == 16'd0) begin
          shift_nxt_s = {rxs_r, shift_r[7:1]};
          cnt_nxt_s   = BIT_LOAD;
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_r == 16'd0) begin
          if (rxs_r) begin
            push_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            ferr_set_s  = 1'b1;
            state_nxt_s = ST_BREAK;
          end
        end else begin
          cnt_nxt_s = cnt_r - 16'd1;
        end
      end
      ST_BREAK: begin
        // A held-low line reports one framing error, then waits for release.
        if (rxs_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO push/pop arbitration; a pop on a full FIFO frees the slot the push needs.
  always_comb begin
    fifo_full_s  = (level_r == LVL_FULL);
    fifo_empty_s = (level_r == LVL_ZERO);
    pop_s        = rd_pop & ~fifo_empty_s;
    wr_en_s      = push_s & (~fifo_full_s | pop_s);
    ovr_set_s    = push_s & fifo_full_s & ~pop_s;
    if (wr_en_s && !pop_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (pop_s && !wr_en_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // FIFO storage, pointers and fill level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= LVL_ZERO;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
    end
  end

  // Sticky error flags; a same-cycle set beats clr_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= ferr_set_s | (frame_err_r & ~clr_err);
      overrun_r   <= ovr_set_s | (overrun_r & ~clr_err);
    end
  end

  assign data_out   = mem_r[rd_ptr_r];
  assign data_avail = ~fifo_empty_s;
  assign fifo_level = level_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_serial_rx_port.sv
// Self-checking bench for serial_rx_port: directed table, hand-written corner
// sequences, then random frames/pops checked against a queue-based model.
module tb_serial_rx_port;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;

  localparam int OP_SEND   = 0;
  localparam int OP_BAD    = 1;
  localparam int OP_POP    = 2;
  localparam int OP_CLR    = 3;
  localparam int OP_GLITCH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_rx;
  logic       rd_pop;
  logic       clr_err;
  logic [7:0] data_out;
  logic       data_avail;
  logic [2:0] fifo_level;
  logic       frame_err;
  logic       overrun;

  serial_rx_port #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_rx  (serial_rx),
    .rd_pop     (rd_pop),
    .clr_err    (clr_err),
    .data_out   (data_out),
    .data_avail (data_avail),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         op;
    logic [7:0] dat;
    int         lvl;
    logic [7:0] head;
    logic       fe;
    logic       ov;
  } vec_t;

  vec_t vecs [20];

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned mq [$];
  logic         m_fe;
  logic         m_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int lvl, input logic [7:0] head,
                               input logic fe, input logic ov);
    check({tag, " level"}, 32'(fifo_level), 32'(lvl));
    check({tag, " avail"}, 32'(data_avail), 32'(lvl != 0));
    check({tag, " frame_err"}, 32'(frame_err), 32'(fe));
    check({tag, " overrun"}, 32'(overrun), 32'(ov));
    if (lvl != 0) check({tag, " head"}, 32'(data_out), 32'(head));
  endtask

  task automatic check_model(input string tag);
    logic [7:0] hd;
    hd = (mq.size() != 0) ? mq[0] : 8'h00;
    check_outputs(tag, mq.size(), hd, m_fe, m_ov);
  endtask

  // One 8N1 frame driven on negedges; index i is the negedge count from the start bit.
  // stop_low>0 holds the stop bit low that many cycles; pop_at/clr_at pulse a strobe
  // seen by the posedge following negedge i; rst_at asserts reset mid-frame and aborts.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int pop_at,
                            input int clr_at, input int rst_at, output int first_avail);
    int         total;
    logic [7:0] sh;
    total       = 144 + ((stop_low > 0) ? stop_low : 0) + 16;
    first_avail = -1;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (first_avail < 0 && data_avail === 1'b1) first_avail = i;
      if (i == rst_at) begin
        reset     = 1'b1;
        serial_rx = 1'b1;
        rd_pop    = 1'b0;
        clr_err   = 1'b0;
        #1;
        check_outputs("async reset", 0, 8'h00, 1'b0, 1'b0);
        check("async reset data_out", 32'(data_out), 32'h0);
        return;
      end
      rd_pop  = (i == pop_at);
      clr_err = (i == clr_at);
      if (i < 16) begin
        serial_rx = 1'b0;
      end else if (i < 144) begin
        sh        = b >> ((i - 16) / 16);
        serial_rx = sh[0];
      end else if (i < 144 + stop_low) begin
        serial_rx = 1'b0;
      end else begin
        serial_rx = 1'b1;
      end
    end
    @(negedge clk);
    rd_pop  = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int fa;
    send_frame(b, 0, -1, -1, -1, fa);
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    serial_rx = 1'b0;
    repeat (len) @(negedge clk);
    serial_rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
  endtask

  task automatic pulse_pop();
    @(negedge clk);
    rd_pop = 1'b1;
    @(negedge clk);
    rd_pop = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, " popped"}, 32'(data_out), 32'(exp));
    pulse_pop();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         fa;
    int         r;
    logic [7:0] b;

    reset     = 1'b1;
    serial_rx = 1'b1;
    rd_pop    = 1'b0;
    clr_err   = 1'b0;

    vecs[0]  = '{OP_SEND,   8'hA5, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{OP_POP,    8'hA5, 0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{OP_GLITCH, 8'h00, 0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{OP_SEND,   8'h3C, 1, 8'h3C, 1'b0, 1'b0};
    vecs[4]  = '{OP_POP,    8'h3C, 0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{OP_BAD,    8'h55, 0, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{OP_CLR,    8'h00, 0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{OP_SEND,   8'h01, 1, 8'h01, 1'b0, 1'b0};
    vecs[8]  = '{OP_POP,    8'h01, 0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{OP_SEND,   8'h10, 1, 8'h10, 1'b0, 1'b0};
    vecs[10] = '{OP_SEND,   8'h11, 2, 8'h10, 1'b0, 1'b0};
    vecs[11] = '{OP_SEND,   8'h12, 3, 8'h10, 1'b0, 1'b0};
    vecs[12] = '{OP_SEND,   8'h13, 4, 8'h10, 1'b0, 1'b0};
    vecs[13] = '{OP_SEND,   8'h14, 4, 8'h10, 1'b0, 1'b1};
    vecs[14] = '{OP_POP,    8'h10, 3, 8'h11, 1'b0, 1'b1};
    vecs[15] = '{OP_POP,    8'h11, 2, 8'h12, 1'b0, 1'b1};
    vecs[16] = '{OP_POP,    8'h12, 1, 8'h13, 1'b0, 1'b1};
    vecs[17] = '{OP_POP,    8'h13, 0, 8'h00, 1'b0, 1'b1};
    vecs[18] = '{OP_POP,    8'h00, 0, 8'h00, 1'b0, 1'b1};
    vecs[19] = '{OP_CLR,    8'h00, 0, 8'h00, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 8'h00, 1'b0, 1'b0);
    check("reset data_out", 32'(data_out), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Directed table: entry 18 pops an empty FIFO, which must change nothing.
    for (int k = 0; k < 20; k++) begin
      case (vecs[k].op)
        OP_SEND:   send_byte(vecs[k].dat);
        OP_BAD:    send_frame(vecs[k].dat, 40, -1, -1, -1, fa);
        OP_POP: begin
          if (vecs[k].lvl != 0 || vecs[k].dat != 8'h00)
            check($sformatf("vec%0d popped", k), 32'(data_out), 32'(vecs[k].dat));
          pulse_pop();
        end
        OP_CLR:    pulse_clr();
        OP_GLITCH: glitch(5);
        default:   ;
      endcase
      repeat (2) @(negedge clk);
      check_outputs($sformatf("vec%0d", k), vecs[k].lvl, vecs[k].head, vecs[k].fe, vecs[k].ov);
    end

    // Full FIFO with a pop on the push edge: push accepted, no overrun, old head leaves.
    send_byte(8'h21);
    send_byte(8'h22);
    send_byte(8'h23);
    send_byte(8'h24);
    check_outputs("fill4", 4, 8'h21, 1'b0, 1'b0);
    send_frame(8'h25, 0, 154, -1, -1, fa);
    check_outputs("pop on full push", 4, 8'h22, 1'b0, 1'b0);
    pop_expect("drainA0", 8'h22);
    pop_expect("drainA1", 8'h23);
    pop_expect("drainA2", 8'h24);
    pop_expect("drainA3", 8'h25);
    check_outputs("drainA empty", 0, 8'h00, 1'b0, 1'b0);

    // clr_err in the same cycle as an overrun push: set wins.
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    send_byte(8'h34);
    send_frame(8'h35, 0, -1, 154, -1, fa);
    check_outputs("clr vs overrun", 4, 8'h31, 1'b0, 1'b1);
    pulse_clr();
    check_outputs("clr overrun", 4, 8'h31, 1'b0, 1'b0);
    pop_expect("drainB0", 8'h31);
    pop_expect("drainB1", 8'h32);
    pop_expect("drainB2", 8'h33);
    pop_expect("drainB3", 8'h34);

    // Push-edge latency: 2 synchronizer edges, the IDLE edge that sees rxs low,
    // then CLK_DIV/2 + 9*CLK_DIV; the push is visible from the following negedge.
    send_frame(8'h5A, 0, -1, -1, -1, fa);
    check("push latency", 32'(fa), 32'(3 + CLK_DIV / 2 + 9 * CLK_DIV));
    check_outputs("latency byte", 1, 8'h5A, 1'b0, 1'b0);

    // Reset mid data bit 3 with content and a flag present; then a clean 0x7E.
    send_frame(8'h66, 30, -1, -1, -1, fa);
    check_outputs("pre-reset", 1, 8'h5A, 1'b1, 1'b0);
    send_frame(8'h99, 0, -1, -1, 16 + 3 * CLK_DIV + 6, fa);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_outputs("after reset idle", 0, 8'h00, 1'b0, 1'b0);
    send_byte(8'h7E);
    check_outputs("post-reset 7E", 1, 8'h7E, 1'b0, 1'b0);

    // Random phase against a queue model of the FIFO and flags.
    mq.delete();
    mq.push_back(8'h7E);
    m_fe = 1'b0;
    m_ov = 1'b0;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      b = 8'($urandom);
      if (r <= 4) begin
        send_byte(b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ov = 1'b1;
      end else if (r == 5) begin
        send_frame(b, $urandom_range(20, 40), -1, -1, -1, fa);
        m_fe = 1'b1;
      end else if (r <= 7) begin
        if (mq.size() != 0) begin
          check($sformatf("rnd%0d popped", k), 32'(data_out), 32'(mq[0]));
          void'(mq.pop_front());
        end
        pulse_pop();
      end else if (r == 8) begin
        pulse_clr();
        m_fe = 1'b0;
        m_ov = 1'b0;
      end else begin
        glitch($urandom_range(1, 6));
      end
      repeat ($urandom_range(1, 20)) @(negedge clk);
      check_model($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
